fsm_multi_ch_ctrl: RTL

//  Multi-channel insert/release sequencer; successor to the single-channel EN/DIRECTION/START/FAULT controller.
//  N_CH independent per-channel FSMs drive EN_INSERT/EN_RELEASE/EN_RESET/EN_ALARM.

---
 rtl/fsm_multi_ch_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fsm_multi_ch_ctrl.sv
// Multi-channel insert/release sequencer: one FSM per channel with
// watchdog, timed reset phase, latched alarm and optional motion exclusion.
module fsm_multi_ch_ctrl #(
  parameter int N_CH        = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int RESET_CYC   = 4,
  parameter bit EXCL        = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] EN,
  input  logic [N_CH-1:0] DIRECTION,
  input  logic [N_CH-1:0] START,
  input  logic [N_CH-1:0] FAULT,
  input  logic [N_CH-1:0] DONE,
  input  logic [N_CH-1:0] ALARM_CLR,
  output logic [N_CH-1:0] EN_INSERT,
  output logic [N_CH-1:0] EN_RELEASE,
  output logic [N_CH-1:0] EN_RESET,
  output logic [N_CH-1:0] EN_ALARM,
  output logic [N_CH-1:0] TO_FLAG,
  output logic            ANY_ALARM
);

  localparam int MAXC = (TIMEOUT_CYC > RESET_CYC) ? TIMEOUT_CYC : RESET_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] RS_LAST = CW'(RESET_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INSERT,
    S_RELEASE,
    S_RESET,
    S_ALARM
  } state_t;

  state_t          st_q  [N_CH];
  state_t          st_d  [N_CH];
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [N_CH-1:0] to_d;
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] grant;
  logic [N_CH-1:0] alarm_d;
  logic            busy;
  logic            taken;

  // Exclusion looks at current state only, so a channel leaving motion
  // frees the slot one edge later.
  always_comb begin
    busy  = |(EN_INSERT | EN_RELEASE);
    grant = '0;
    taken = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      req[i] = (st_q[i] == S_IDLE) && EN[i] && START[i] && !FAULT[i];
    end
    if (!EXCL) begin
      grant = '1;
    end else if (!busy) begin
      for (int i = 0; i < N_CH; i++) begin
        if (req[i] && !taken) begin
          grant[i] = 1'b1;
          taken    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    to_d    = TO_FLAG;
    alarm_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      unique case (st_q[i])
        S_IDLE: begin
          if (FAULT[i]) begin
            st_d[i] = S_ALARM;
            to_d[i] = 1'b0;
          end else if (EN[i] && START[i] && grant[i]) begin
            st_d[i]  = DIRECTION[i] ? S_INSERT : S_RELEASE;
            cnt_d[i] = '0;
          end
        end
        S_INSERT, S_RELEASE: begin
          if (FAULT[i]) begin
            st_d[i] = S_ALARM;
            to_d[i] = 1'b0;
          end else if (DONE[i] || !EN[i]) begin
            st_d[i]  = S_RESET;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == TO_LAST) begin
            st_d[i] = S_ALARM;
            to_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        S_RESET: begin
          if (FAULT[i]) begin
            st_d[i] = S_ALARM;
            to_d[i] = 1'b0;
          end else if (cnt_q[i] == RS_LAST) begin
            st_d[i]  = S_IDLE;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        S_ALARM: begin
          if (ALARM_CLR[i] && !FAULT[i]) begin
            st_d[i]  = S_RESET;
            cnt_d[i] = '0;
            to_d[i]  = 1'b0;
          end
        end
        default: begin
          st_d[i]  = S_IDLE;
          cnt_d[i] = '0;
        end
      endcase
      alarm_d[i] = (st_d[i] == S_ALARM);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]  <= S_IDLE;
        cnt_q[i] <= '0;
      end
      EN_INSERT  <= '0;
      EN_RELEASE <= '0;
      EN_RESET   <= '0;
      EN_ALARM   <= '0;
      TO_FLAG    <= '0;
      ANY_ALARM  <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]       <= st_d[i];
        cnt_q[i]      <= cnt_d[i];
        EN_INSERT[i]  <= (st_d[i] == S_INSERT);
        EN_RELEASE[i] <= (st_d[i] == S_RELEASE);
        EN_RESET[i]   <= (st_d[i] == S_RESET);
      end
      EN_ALARM  <= alarm_d;
      TO_FLAG   <= to_d & alarm_d;
      ANY_ALARM <= |alarm_d;
    end
  end

endmodule
